// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between WB and the MDU, tracks pending
// MDU destinations for decode hazards, and forces a steal cycle when the MDU starves.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        hazard_stall,
  output logic        pipe_stall,
  output logic        RegWrite,
  output logic [4:0]  write_register,
  output logic [31:0] write_data
);

  localparam int unsigned DATA_W     = 32;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT - 1);

  typedef enum logic {IDLE, STEAL} state_t;

  state_t             state_q, state_d;
  logic [3:0]         starve_q, starve_d;
  logic [31:0]        busy_q, busy_d;

  logic               sel_mdu;
  logic               grant;
  logic               we_sel;
  logic [4:0]         reg_sel;
  logic [DATA_W-1:0]  data_sel;
  logic               handshake;

  // Port selection: WB wins in IDLE, the MDU owns the port during a steal
  always_comb begin
    sel_mdu = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!wb_RegWrite && mdu_valid) begin
          sel_mdu = 1'b1;
          grant   = 1'b1;
        end
      end
      STEAL: begin
        sel_mdu = 1'b1;
        grant   = 1'b1;
      end
      default: begin
        sel_mdu = 1'b0;
        grant   = 1'b0;
      end
    endcase
  end

  assign we_sel    = sel_mdu ? mdu_valid : wb_RegWrite;
  assign reg_sel   = sel_mdu ? mdu_reg   : wb_reg;
  assign data_sel  = sel_mdu ? mdu_data  : wb_data;
  assign handshake = mdu_valid && grant;

  // r0 writes are dropped, but the MDU handshake still completes
  assign RegWrite       = reset_n && we_sel && (reg_sel != 5'd0);
  assign write_register = reset_n ? reg_sel  : 5'd0;
  assign write_data     = reset_n ? data_sel : '0;
  assign mdu_ready      = reset_n && grant;
  assign pipe_stall     = (state_q == STEAL);

  // Starvation tracking and steal scheduling
  always_comb begin
    state_d  = IDLE;
    starve_d = 4'd0;
    if (state_q == IDLE && mdu_valid && !grant) begin
      if (starve_q == STARVE_MAX) begin
        state_d = STEAL;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Scoreboard: a new issue overrides a completion to the same register
  always_comb begin
    busy_d = busy_q;
    if (handshake) begin
      busy_d[mdu_reg] = 1'b0;
    end
    if (issue_valid && issue_reg != 5'd0) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      busy_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  assign hazard_stall = ((rs != 5'd0) && busy_q[rs]) || ((rt != 5'd0) && busy_q[rt]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with a queue-based scoreboard and
// a hand-written reset-during-steal sequence.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic        wb_RegWrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard_stall;
  logic        pipe_stall;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wb_we;
    logic [4:0]  wb_r;
    logic [31:0] wb_d;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  rs_v;
    logic [4:0]  rt_v;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_ps;
    logic        e_hz;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_RegWrite(wb_RegWrite), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .rs(rs), .rt(rt),
    .hazard_stall(hazard_stall), .pipe_stall(pipe_stall),
    .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string n, logic wbwe, logic [4:0] wbr, logic [31:0] wbd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic iv, logic [4:0] ir, logic [4:0] rsv, logic [4:0] rtv,
                              logic ewe, logic [4:0] ewr, logic [31:0] ewd,
                              logic erdy, logic eps, logic ehz);
    vec_t v;
    v.name = n; v.wb_we = wbwe; v.wb_r = wbr; v.wb_d = wbd;
    v.mv = mv; v.mr = mr; v.md = md; v.iv = iv; v.ir = ir;
    v.rs_v = rsv; v.rt_v = rtv; v.e_we = ewe; v.e_wr = ewr; v.e_wd = ewd;
    v.e_rdy = erdy; v.e_ps = eps; v.e_hz = ehz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    wb_RegWrite = v.wb_we; wb_reg = v.wb_r; wb_data = v.wb_d;
    mdu_valid = v.mv; mdu_reg = v.mr; mdu_data = v.md;
    issue_valid = v.iv; issue_reg = v.ir; rs = v.rs_v; rt = v.rt_v;
    exp_q.push_back(v);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", v.name);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".RegWrite"},   32'(RegWrite),     32'(e.e_we));
      chk({e.name, ".mdu_ready"},  32'(mdu_ready),    32'(e.e_rdy));
      chk({e.name, ".pipe_stall"}, 32'(pipe_stall),   32'(e.e_ps));
      chk({e.name, ".hazard"},     32'(hazard_stall), 32'(e.e_hz));
      if (e.e_we) begin
        chk({e.name, ".write_register"}, 32'(write_register), 32'(e.e_wr));
        chk({e.name, ".write_data"},     write_data,          e.e_wd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_RegWrite = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD;
    mdu_valid = 1'b1; mdu_reg = 5'd4; mdu_data = 32'hBEEF;
    issue_valid = 1'b0; issue_reg = 5'd0; rs = 5'd0; rt = 5'd0;
    #12;
    chk("rst.RegWrite",       32'(RegWrite),       32'd0);
    chk("rst.write_register", 32'(write_register), 32'd0);
    chk("rst.write_data",     write_data,          32'd0);
    chk("rst.mdu_ready",      32'(mdu_ready),      32'd0);
    chk("rst.pipe_stall",     32'(pipe_stall),     32'd0);

    wb_RegWrite = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    //              name         we r   data          mv r   data          iv ir  rs  rt  ewe ewr ewd           rdy ps hz
    vecs.push_back(mk("idle",     0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  5,  0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("wb_prio",  1, 8,  32'h1234,     1, 9,  32'hAAAA0009, 0, 0,  0,  0,  1, 8,  32'h1234,     0, 0, 0));
    vecs.push_back(mk("mdu_r9",   0, 0,  32'h0,        1, 9,  32'hAAAA0009, 0, 0,  0,  0,  1, 9,  32'hAAAA0009, 1, 0, 0));
    vecs.push_back(mk("issue12",  0, 0,  32'h0,        0, 0,  32'h0,        1, 12, 12, 0,  0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("hz_rs12",  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  12, 0,  0, 0,  32'h0,        0, 0, 1));
    vecs.push_back(mk("hs_r12",   0, 0,  32'h0,        1, 12, 32'hC0DE000C, 0, 0,  3,  12, 1, 12, 32'hC0DE000C, 1, 0, 1));
    vecs.push_back(mk("hz_clr12", 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  12, 12, 0, 0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("setclr7",  0, 0,  32'h0,        1, 7,  32'h77,       1, 7,  0,  0,  1, 7,  32'h77,       1, 0, 0));
    vecs.push_back(mk("hz_rt7",   0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  7,  0, 0,  32'h0,        0, 0, 1));
    vecs.push_back(mk("mdu_r0",   0, 0,  32'h0,        1, 0,  32'h5,        1, 0,  0,  0,  0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk("busy7",    0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  0,  0, 0,  32'h0,        0, 0, 1));
    vecs.push_back(mk("wb_r0",    1, 0,  32'hFF,       0, 0,  32'h0,        0, 0,  12, 0,  0, 0,  32'h0,        0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk($sformatf("starve%0d", i + 1), 1, 5'(20 + i), 32'(32'h20 + i),
                        1, 10, 32'h1010, 0, 0, 0, 0, 1, 5'(20 + i), 32'(32'h20 + i), 0, 0, 0));
    end
    vecs.push_back(mk("steal",    1, 24, 32'h24,       1, 10, 32'h1010,     0, 0,  0,  0,  1, 10, 32'h1010,     1, 1, 0));
    vecs.push_back(mk("wb_held",  1, 24, 32'h24,       0, 0,  32'h0,        0, 0,  0,  0,  1, 24, 32'h24,       0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk($sformatf("blk11_%0d", i + 1), 1, 25, 32'h25,
                        1, 11, 32'hB0B0000B, 0, 0, 7, 0, 1, 25, 32'h25, 0, 0, 1));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // The last four vectors starved r11, so the arbiter is now in a steal cycle
    rs = 5'd7;
    #1;
    chk("steal2.pipe_stall",     32'(pipe_stall),     32'd1);
    chk("steal2.mdu_ready",      32'(mdu_ready),      32'd1);
    chk("steal2.write_register", 32'(write_register), 32'd11);
    reset_n = 1'b0;
    #1;
    chk("midrst.pipe_stall",     32'(pipe_stall),     32'd0);
    chk("midrst.mdu_ready",      32'(mdu_ready),      32'd0);
    chk("midrst.RegWrite",       32'(RegWrite),       32'd0);
    chk("midrst.write_register", 32'(write_register), 32'd0);
    chk("midrst.write_data",     write_data,          32'd0);
    chk("midrst.hazard_busy7",   32'(hazard_stall),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wb_RegWrite = 1'b0;
    #1;
    chk("postrst.mdu_ready",      32'(mdu_ready),      32'd1);
    chk("postrst.RegWrite",       32'(RegWrite),       32'd1);
    chk("postrst.write_register", 32'(write_register), 32'd11);
    chk("postrst.write_data",     write_data,          32'hB0B0000B);
    chk("postrst.pipe_stall",     32'(pipe_stall),     32'd0);
    @(posedge clk);
    #1;
    mdu_valid = 1'b0;
    #1;
    chk("final.mdu_ready", 32'(mdu_ready), 32'd0);
    chk("final.RegWrite",  32'(RegWrite),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
